// File: rtl/gfx_pkg.sv
// gfx_pkg: shared definitions for the VRAM arbiter slice.
//   - FSM state encoding (IDLE / ACCESS / RELEASE)
//   - default VRAM address / data widths
package gfx_pkg;
  localparam int GFX_ADDR_W = 15;
  localparam int GFX_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/gfx_rr_arbiter.sv
// gfx_rr_arbiter: combinational round-robin selector.
//   req       in   N    request vector
//   last      in   LW   index granted last time; search starts at last+1
//   grant_idx out  LW   winning index (valid when any=1)
//   any       out  1    at least one request present
// With N=1 the search collapses to a fixed grant of index 0.
module gfx_rr_arbiter #(
  parameter int N = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] grant_idx,
  output logic          any
);
  always_comb begin
    grant_idx = '0;
    any       = |req;
    // Walk from the farthest offset down so the nearest requester after
    // 'last' is the one left standing.
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) grant_idx = LW'((int'(last) + i) % N);
    end
  end
endmodule

// File: rtl/gfx_vram_arbiter.sv
// gfx_vram_arbiter: single-port VRAM arbiter, VGA fetch has absolute
// priority, DMA channels share the rest round-robin.
//   i_clk / i_rst_b          clock, synchronous active-low reset
//   i_vga_* / o_vga_*        VGA fetch request, address, returned byte, valid pulse
//   i_dma_* / o_dma_*        per-channel req/we/addr/wdata (flattened), ack, rdata
//   o_ram_* / i_ram_rdata    async SRAM strobes (active low), address, data
//   o_vga_underrun           sticky VGA deadline miss flag
// Slot = IDLE(grant) + ACCESS (RAM_WAIT+1 cycles) + RELEASE (ack) cycle.
// Optional feature: define GFX_ARB_UNDERRUN_EN to build the VGA deadline
// counter; otherwise o_vga_underrun is tied low.
module gfx_vram_arbiter
  import gfx_pkg::*;
#(
  parameter int ADDR_WIDTH   = GFX_ADDR_W,
  parameter int DATA_WIDTH   = GFX_DATA_W,
  parameter int DMA_CHANNELS = 2,
  parameter int RAM_WAIT     = 1,
  parameter int VGA_DEADLINE = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_b,
  input  logic                             i_vga_req,
  input  logic [ADDR_WIDTH-1:0]            i_vga_addr,
  output logic [DATA_WIDTH-1:0]            o_vga_data,
  output logic                             o_vga_valid,
  input  logic [DMA_CHANNELS-1:0]          i_dma_req,
  input  logic [DMA_CHANNELS-1:0]          i_dma_we,
  input  logic [DMA_CHANNELS*ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DMA_CHANNELS*DATA_WIDTH-1:0] i_dma_wdata,
  output logic [DMA_CHANNELS-1:0]          o_dma_ack,
  output logic [DATA_WIDTH-1:0]            o_dma_rdata,
  output logic [ADDR_WIDTH-1:0]            o_ram_addr,
  output logic                             o_ram_ce_b,
  output logic                             o_ram_oe_b,
  output logic                             o_ram_we_b,
  output logic [DATA_WIDTH-1:0]            o_ram_wdata,
  output logic                             o_ram_wdata_oe,
  input  logic [DATA_WIDTH-1:0]            i_ram_rdata,
  output logic                             o_vga_underrun
);
  localparam int LW = (DMA_CHANNELS > 1) ? $clog2(DMA_CHANNELS) : 1;
  localparam int NP = 1 << LW;  // channel arrays padded so any LW-bit index is in range
  localparam int CW = $clog2(RAM_WAIT + 1);

  arb_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [LW-1:0] last_q, own_ch, rr_idx;
  logic          rr_any, grant, grant_vga, own_vga, we_q, we_nxt, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [ADDR_WIDTH-1:0] dma_addr  [NP];
  logic [DATA_WIDTH-1:0] dma_wdata [NP];
  logic [NP-1:0]         dma_we;

  for (genvar k = 0; k < NP; k++) begin : g_unpack
    if (k < DMA_CHANNELS) begin : g_ch
      assign dma_addr[k]  = i_dma_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign dma_wdata[k] = i_dma_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      assign dma_we[k]    = i_dma_we[k];
    end else begin : g_pad
      assign dma_addr[k]  = '0;
      assign dma_wdata[k] = '0;
      assign dma_we[k]    = 1'b0;
    end
  end

  gfx_rr_arbiter #(.N(DMA_CHANNELS)) u_rr (
    .req       (i_dma_req),
    .last      (last_q),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  assign done = (state == ACCESS) && (cnt == CW'(RAM_WAIT));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    grant_vga = 1'b0;
    we_nxt    = we_q;
    case (state)
      IDLE: if (i_vga_req || rr_any) begin
        grant     = 1'b1;
        grant_vga = i_vga_req;
        state_nxt = ACCESS;
        cnt_nxt   = '0;
        we_nxt    = i_vga_req ? 1'b0 : dma_we[rr_idx];
      end
      ACCESS: if (done) state_nxt = RELEASE;
              else      cnt_nxt   = cnt + CW'(1);
      RELEASE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from next-state so they change cleanly on the
  // clock edge; we_b skips the first ACCESS cycle for address setup and
  // the data driver stays on through RELEASE for hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      state          <= IDLE;
      cnt            <= '0;
      last_q         <= LW'(DMA_CHANNELS - 1);
      own_vga        <= 1'b0;
      own_ch         <= '0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      o_ram_ce_b     <= 1'b1;
      o_ram_oe_b     <= 1'b1;
      o_ram_we_b     <= 1'b1;
      o_ram_wdata_oe <= 1'b0;
      o_vga_valid    <= 1'b0;
      o_vga_data     <= '0;
      o_dma_rdata    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      we_q  <= we_nxt;
      if (grant) begin
        own_vga <= grant_vga;
        own_ch  <= rr_idx;
        addr_q  <= grant_vga ? i_vga_addr : dma_addr[rr_idx];
        wdata_q <= grant_vga ? '0 : dma_wdata[rr_idx];
        if (!grant_vga) last_q <= rr_idx;  // VGA slots leave the rotation alone
      end
      o_ram_ce_b     <= !(state_nxt == ACCESS);
      o_ram_oe_b     <= !(state_nxt == ACCESS && !we_nxt);
      o_ram_we_b     <= !(state_nxt == ACCESS && we_nxt && cnt_nxt != '0);
      o_ram_wdata_oe <= we_nxt && (state_nxt == ACCESS || state_nxt == RELEASE);
      o_vga_valid    <= done && own_vga;
      if (done && own_vga) o_vga_data <= i_ram_rdata;
      if (done && !own_vga && !we_q) o_dma_rdata <= i_ram_rdata;
    end
  end

  for (genvar k = 0; k < DMA_CHANNELS; k++) begin : g_ack
    always_ff @(posedge i_clk) begin
      if (!i_rst_b) o_dma_ack[k] <= 1'b0;
      else          o_dma_ack[k] <= done && !own_vga && (own_ch == LW'(k));
    end
  end

  assign o_ram_addr  = addr_q;
  assign o_ram_wdata = wdata_q;

`ifdef GFX_ARB_UNDERRUN_EN
  localparam int DLW = $clog2(VGA_DEADLINE + 1);
  logic [DLW-1:0] dl_cnt;
  logic           underrun_q, vga_wait;

  // Waiting = VGA asking while someone else holds the bus. The IDLE cycle
  // grants VGA immediately, and its own slot is service, not waiting.
  assign vga_wait = i_vga_req && (state != IDLE) && !own_vga;

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      dl_cnt     <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (o_vga_valid) dl_cnt <= '0;
      else if (vga_wait && dl_cnt != DLW'(VGA_DEADLINE)) dl_cnt <= dl_cnt + DLW'(1);
      if (dl_cnt == DLW'(VGA_DEADLINE)) underrun_q <= 1'b1;
    end
  end
  assign o_vga_underrun = underrun_q;
`else
  logic unused_cfg;
  assign unused_cfg     = (VGA_DEADLINE == 0);
  assign o_vga_underrun = 1'b0;
`endif
endmodule

// File: tb/tb_gfx_vram_arbiter.sv
// Directed bench: instance A (4 channels, RAM_WAIT=1) and instance B
// (1 channel, RAM_WAIT=4), each with a behavioural async SRAM.
module tb_gfx_vram_arbiter;
  localparam int AW = 15, DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic          rst_a_b, vga_req_a, vga_valid_a, ce_a, oe_a, we_a, wdoe_a, und_a;
  logic [AW-1:0] vga_addr_a, raddr_a;
  logic [DW-1:0] vga_data_a, drdata_a, rwdata_a, rrdata_a;
  logic [3:0]    dreq_a, dwe_a, ack_a;
  logic [4*AW-1:0] daddr_a;
  logic [4*DW-1:0] dwdata_a;
  logic [DW-1:0] mem_a [1<<AW];
  assign rrdata_a = mem_a[raddr_a];
  always @(posedge clk) if (!we_a) mem_a[raddr_a] <= rwdata_a;

  // instance B
  logic          rst_b_b, vga_req_b, vga_valid_b, ce_b, oe_b, we_b, wdoe_b, und_b;
  logic [AW-1:0] vga_addr_b, raddr_b, daddr_b;
  logic [DW-1:0] vga_data_b, drdata_b, rwdata_b, rrdata_b, dwdata_b;
  logic [0:0]    dreq_b, dwe_b, ack_b;
  logic [DW-1:0] mem_b [1<<AW];
  assign rrdata_b = mem_b[raddr_b];
  always @(posedge clk) if (!we_b) mem_b[raddr_b] <= rwdata_b;

  gfx_vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMA_CHANNELS(4),
                     .RAM_WAIT(1), .VGA_DEADLINE(4)) dut_a (
    .i_clk(clk), .i_rst_b(rst_a_b), .i_vga_req(vga_req_a), .i_vga_addr(vga_addr_a),
    .o_vga_data(vga_data_a), .o_vga_valid(vga_valid_a), .i_dma_req(dreq_a),
    .i_dma_we(dwe_a), .i_dma_addr(daddr_a), .i_dma_wdata(dwdata_a), .o_dma_ack(ack_a),
    .o_dma_rdata(drdata_a), .o_ram_addr(raddr_a), .o_ram_ce_b(ce_a), .o_ram_oe_b(oe_a),
    .o_ram_we_b(we_a), .o_ram_wdata(rwdata_a), .o_ram_wdata_oe(wdoe_a),
    .i_ram_rdata(rrdata_a), .o_vga_underrun(und_a));

  gfx_vram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMA_CHANNELS(1),
                     .RAM_WAIT(4), .VGA_DEADLINE(4)) dut_b (
    .i_clk(clk), .i_rst_b(rst_b_b), .i_vga_req(vga_req_b), .i_vga_addr(vga_addr_b),
    .o_vga_data(vga_data_b), .o_vga_valid(vga_valid_b), .i_dma_req(dreq_b),
    .i_dma_we(dwe_b), .i_dma_addr(daddr_b), .i_dma_wdata(dwdata_b), .o_dma_ack(ack_b),
    .o_dma_rdata(drdata_b), .o_ram_addr(raddr_b), .o_ram_ce_b(ce_b), .o_ram_oe_b(oe_b),
    .o_ram_we_b(we_b), .o_ram_wdata(rwdata_b), .o_ram_wdata_oe(wdoe_b),
    .i_ram_rdata(rrdata_b), .o_vga_underrun(und_b));

  int total = 0, bad = 0;
  int cyc, multi = 0;
  int ce_lo[2], oe_lo[2], we_lo[2], wdoe_hi[2], we_first[2], vga_t[2];
  int ack_ch[$], ack_t[$];
  int ackb_t;
  bit hold;
  logic [DW-1:0] rdata_a, vdata_a, vdata_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      ce_lo[i] = 0; oe_lo[i] = 0; we_lo[i] = 0; wdoe_hi[i] = 0;
      we_first[i] = -1; vga_t[i] = -1;
    end
    ack_ch.delete(); ack_t.delete();
    ackb_t = -1;
  endtask

  // Advance n cycles sampling at negedge; requesters drop on their ack
  // (DMA on A only when hold is clear).
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (!ce_a) ce_lo[0]++;
      if (!oe_a) oe_lo[0]++;
      if (!we_a) begin we_lo[0]++; if (we_first[0] < 0) we_first[0] = cyc; end
      if (wdoe_a) wdoe_hi[0]++;
      if (!ce_b) ce_lo[1]++;
      if (!oe_b) oe_lo[1]++;
      if (!we_b) begin we_lo[1]++; if (we_first[1] < 0) we_first[1] = cyc; end
      if (wdoe_b) wdoe_hi[1]++;
      if ($countones({ack_a, vga_valid_a}) > 1) multi++;
      if (vga_valid_a) begin vga_t[0] = cyc; vdata_a = vga_data_a; vga_req_a = 1'b0; end
      for (int k = 0; k < 4; k++) begin
        if (ack_a[k]) begin
          ack_ch.push_back(k); ack_t.push_back(cyc); rdata_a = drdata_a;
          if (!hold) dreq_a[k] = 1'b0;
        end
      end
      if (vga_valid_b) begin vga_t[1] = cyc; vdata_b = vga_data_b; vga_req_b = 1'b0; end
      if (ack_b[0]) begin ackb_t = cyc; dreq_b = 1'b0; end
    end
  endtask

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    hold = 1'b0;
    rst_a_b = 1'b0; rst_b_b = 1'b0;
    vga_req_a = 1'b0; vga_addr_a = '0; dwe_a = '0; dwdata_a = '0; daddr_a = '0;
    vga_req_b = 1'b0; vga_addr_b = '0; dreq_b = '0; dwe_b = '0; daddr_b = '0; dwdata_b = '0;
    mem_a[15'h1234] = 8'hA5; mem_a[15'h0100] = 8'h3C; mem_a[15'h0007] = 8'h00;
    for (int k = 0; k < 4; k++) mem_a[15'h0200 + k] = 8'h10 + 8'(k);
    // request held through reset must not start a slot
    dreq_a = 4'b0001; daddr_a[0 +: AW] = 15'h1234;
    repeat (3) @(negedge clk);
    chk("rst_ce", ce_a, 1); chk("rst_oe", oe_a, 1); chk("rst_we", we_a, 1);
    chk("rst_wdoe", wdoe_a, 0); chk("rst_valid", vga_valid_a, 0); chk("rst_ack", ack_a, 0);
    chk("rst_addr", raddr_a, 0); chk("rst_wdata", rwdata_a, 0);
    chk("rst_vdata", vga_data_a, 0); chk("rst_rdata", drdata_a, 0);
    chk("rst_und", und_a, 0); chk("rst_ce_b", ce_b, 1);

    // single DMA read, granted on the reset-release edge
    clr(); rst_a_b = 1'b1; rst_b_b = 1'b1;
    watch(5);
    chk("rd_ce_lo", ce_lo[0], 2); chk("rd_oe_lo", oe_lo[0], 2);
    chk("rd_nack", ack_t.size(), 1);
    chk("rd_ack_t", ack_t.size() > 0 ? ack_t[0] : -1, 3);
    chk("rd_ack_ch", ack_ch.size() > 0 ? ack_ch[0] : -1, 0);
    chk("rd_data", rdata_a, 8'hA5); chk("rd_wdoe", wdoe_hi[0], 0);

    // DMA write on ch1
    clr(); dreq_a[1] = 1'b1; dwe_a[1] = 1'b1;
    daddr_a[AW +: AW] = 15'h0007; dwdata_a[DW +: DW] = 8'h5A;
    watch(5);
    chk("wr_we_lo", we_lo[0], 1); chk("wr_we_first", we_first[0], 2);
    chk("wr_wdoe", wdoe_hi[0], 3); chk("wr_oe_lo", oe_lo[0], 0);
    chk("wr_ack_t", ack_t.size() > 0 ? ack_t[0] : -1, 3);
    chk("wr_ack_ch", ack_ch.size() > 0 ? ack_ch[0] : -1, 1);
    chk("wr_mem", mem_a[15'h0007], 8'h5A);
    dwe_a[1] = 1'b0;

    // VGA beats DMA in the same cycle
    clr(); vga_req_a = 1'b1; vga_addr_a = 15'h0100; dreq_a[0] = 1'b1;
    watch(9);
    chk("pri_vga_t", vga_t[0], 3); chk("pri_vdata", vdata_a, 8'h3C);
    chk("pri_ack_t", ack_t.size() > 0 ? ack_t[0] : -1, 7);
    chk("pri_ack_ch", ack_ch.size() > 0 ? ack_ch[0] : -1, 0);

    // round robin over 4 held requests from a fresh reset
    rst_a_b = 1'b0; @(negedge clk); rst_a_b = 1'b1;
    for (int k = 0; k < 4; k++) daddr_a[k*AW +: AW] = 15'h0200 + 15'(k);
    clr(); hold = 1'b1; dreq_a = 4'hF;
    watch(19);
    dreq_a = '0; hold = 1'b0;
    watch(2);
    chk("rr_nack", ack_t.size(), 5);
    if (ack_t.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_ch%0d", i), ack_ch[i], rr_exp[i]);
        chk($sformatf("rr_t%0d", i), ack_t[i], 3 + 4*i);
      end
    end
    chk("rr_data", rdata_a, 8'h10);

    // reset mid-ACCESS: ch2 wins (last=0), gets aborted, then ch0 wins after reset
    clr(); dreq_a = 4'b0101;
    watch(1);
    chk("ab_ce_acc", ce_a, 0); chk("ab_addr", raddr_a, 15'h0202);
    rst_a_b = 1'b0;
    watch(1);
    chk("ab_ce", ce_a, 1); chk("ab_oe", oe_a, 1); chk("ab_we", we_a, 1);
    chk("ab_wdoe", wdoe_a, 0); chk("ab_noack", ack_t.size(), 0);
    rst_a_b = 1'b1;
    watch(9);
    chk("ab_nack", ack_t.size(), 2);
    chk("ab_ch0", ack_ch.size() > 0 ? ack_ch[0] : -1, 0);
    chk("ab_t0", ack_t.size() > 0 ? ack_t[0] : -1, 5);
    chk("ab_ch1", ack_ch.size() > 1 ? ack_ch[1] : -1, 2);
    chk("ab_t1", ack_t.size() > 1 ? ack_t[1] : -1, 9);

    // VGA arriving one cycle into a short write slot is on time
    clr(); dreq_a[1] = 1'b1; dwe_a[1] = 1'b1;
    watch(1);
    vga_req_a = 1'b1; vga_addr_a = 15'h0100;
    watch(9);
    chk("dl_vga_t", vga_t[0], 7); chk("dl_und_a", und_a, 0);
    dwe_a[1] = 1'b0;

    // single-channel instance, long write slot delays VGA past its deadline
    clr(); dreq_b = 1'b1; dwe_b = 1'b1; daddr_b = 15'h0020; dwdata_b = 8'h77;
    watch(1);
    vga_req_b = 1'b1; vga_addr_b = 15'h0020;
    watch(14);
    chk("b_ack_t", ackb_t, 6); chk("b_we_lo", we_lo[1], 4); chk("b_we_first", we_first[1], 2);
    chk("b_wdoe", wdoe_hi[1], 6); chk("b_ce_lo", ce_lo[1], 10);
    chk("b_vga_t", vga_t[1], 13); chk("b_vdata", vdata_b, 8'h77);
`ifdef GFX_ARB_UNDERRUN_EN
    chk("b_und", und_b, 1);
    watch(3);
    chk("b_und_sticky", und_b, 1);
`else
    chk("b_und", und_b, 0);
    watch(3);
    chk("b_und_sticky", und_b, 0);
`endif
    chk("onehot", multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gfx_vram_arbiter.md
GFX_VRAM_ARBITER -- requirements
Module: gfx_vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 15, giving the VRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the VRAM data width.
REQ-003 The block SHALL have parameter DMA_CHANNELS, default 2, giving the number of DMA requesters; legal range 1..8.
REQ-004 The block SHALL have parameter RAM_WAIT, default 1, giving the number of extra ACCESS cycles; legal range 1..7.
REQ-005 The block SHALL have parameter VGA_DEADLINE, default 4, giving the VGA underrun threshold in cycles.
REQ-006 The port list SHALL be as follows, with one clock and a synchronous, active-low reset:
- i_clk  in  1  clock.
- i_rst_b  in  1  synchronous active-low reset.
- i_vga_req  in  1  VGA fetch request.
- i_vga_addr  in  ADDR_WIDTH  VGA fetch address.
- o_vga_data  out  DATA_WIDTH  fetched pixel byte.
- o_vga_valid  out  1  one-cycle pulse; o_vga_data valid.
- i_dma_req  in  DMA_CHANNELS  per-channel request.
- i_dma_we  in  DMA_CHANNELS  per-channel write flag (1 = write).
- i_dma_addr  in  DMA_CHANNELS*ADDR_WIDTH  flattened addresses; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_dma_wdata  in  DMA_CHANNELS*DATA_WIDTH  flattened write data, packed the same way.
- o_dma_ack  out  DMA_CHANNELS  one-cycle completion pulse.
- o_dma_rdata  out  DATA_WIDTH  read data; valid with ack.
- o_ram_addr  out  ADDR_WIDTH  VRAM address.
- o_ram_ce_b / o_ram_oe_b / o_ram_we_b  out  1 each  VRAM strobes, active low.
- o_ram_wdata  out  DATA_WIDTH  VRAM write data.
- o_ram_wdata_oe  out  1  enables the external data-bus driver.
- i_ram_rdata  in  DATA_WIDTH  VRAM read data.
- o_vga_underrun  out  1  sticky underrun flag (see Configuration).

Function
REQ-007 The FSM SHALL have three states: IDLE, ACCESS, RELEASE.
REQ-008 IDLE SHALL do nothing while no request is present, and SHALL go to ACCESS when any request is present.
REQ-009 ACCESS SHALL last exactly RAM_WAIT+1 cycles, counted by a wait counter.
REQ-010 RELEASE SHALL last 1 cycle and then return to IDLE.
REQ-011 A slot SHALL therefore take RAM_WAIT+3 cycles.
REQ-012 Grant is sampled in IDLE; VGA SHALL have absolute priority over all DMA channels.
REQ-013 DMA grant SHALL be round-robin: the search starts at last_granted+1 and wraps modulo DMA_CHANNELS.
REQ-014 last_granted SHALL reset to DMA_CHANNELS-1, so channel 0 wins first.
REQ-015 The granted address, write flag and write data SHALL be registered at grant and held constant through ACCESS and RELEASE.
REQ-016 In ACCESS, o_ram_ce_b SHALL be 0.
REQ-017 For a read, o_ram_oe_b SHALL be 0 for the whole of ACCESS.
REQ-018 For a write, o_ram_we_b SHALL be 0 only in ACCESS cycles 2..RAM_WAIT+1, which provides address setup.
REQ-019 For a write, o_ram_wdata_oe SHALL be 1 throughout ACCESS and RELEASE, which provides data hold.
REQ-020 i_ram_rdata SHALL be captured on the last ACCESS cycle.
REQ-021 The ack/valid pulse SHALL occur in RELEASE, i.e. RAM_WAIT+2 cycles after the grant cycle.
REQ-022 VGA requests SHALL pulse o_vga_valid with o_vga_data; DMA requests SHALL pulse o_dma_ack[k] with o_dma_rdata, and write data is don't-care.
REQ-023 Requesters SHALL hold req, address, write flag and write data stable until ack/valid.
REQ-024 A request still high in the IDLE cycle following RELEASE SHALL be treated as a new request.
REQ-025 A request deasserted before grant SHALL be dropped silently; after grant, the transaction SHALL complete regardless of req.
REQ-026 If VGA and DMA requests arrive simultaneously, VGA SHALL be served and the DMA channel waits; last_granted SHALL be unchanged by VGA slots.
REQ-027 With DMA_CHANNELS=1, the round-robin logic SHALL degenerate to a single fixed grant.
REQ-028 At most one ack/valid bit SHALL be high in any cycle.

Reset
REQ-029 On i_rst_b=0 at a clock edge: the state SHALL be IDLE and the wait counter 0.
REQ-030 On reset, o_ram_ce_b, o_ram_oe_b and o_ram_we_b SHALL be 1, o_ram_wdata_oe 0, and o_vga_valid and o_dma_ack all 0.
REQ-031 On reset, o_vga_data, o_dma_rdata, o_ram_addr and o_ram_wdata SHALL be 0, and o_vga_underrun 0.
REQ-032 A reset during ACCESS or RELEASE SHALL abort the transaction with no ack; strobes SHALL be inactive on the next cycle.

Configuration
REQ-033 With GFX_ARB_UNDERRUN_EN defined, a deadline counter SHALL count cycles while i_vga_req is high and unserved, and SHALL clear on o_vga_valid.
REQ-034 With GFX_ARB_UNDERRUN_EN defined, reaching VGA_DEADLINE SHALL set o_vga_underrun, which is sticky until reset.
REQ-035 Without GFX_ARB_UNDERRUN_EN, o_vga_underrun SHALL be tied to 0 and no counter SHALL be built.

Structure
REQ-036 A shared package gfx_pkg SHALL hold the FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RELEASE=2'd2) and the default widths (GFX_ADDR_W=15, GFX_DATA_W=8).
REQ-037 The round-robin selector SHALL be the sub-module gfx_rr_arbiter, parameterised by N, with inputs req[N-1:0] and last[$clog2(N)] and outputs grant_idx and any.

Verification
REQ-038 Single DMA read: RAM_WAIT=1, ch0 reads 0x1234 holding 0xA5 -> ce_b low 2 cycles, ack[0] at cycle 3 with rdata 0xA5.
REQ-039 DMA write: ch1 writes 0x5A at 0x0007 -> we_b low 1 cycle (2nd ACCESS cycle), wdata_oe high 3 cycles, RAM[0x0007]=0x5A.
REQ-040 VGA priority: VGA and ch0 requests in the same cycle -> VGA valid at cycle 3, ch0 ack at cycle 7.
REQ-041 Round-robin: DMA_CHANNELS=4, all requests held high -> ack order 0,1,2,3,0 at 4-cycle spacing.
REQ-042 Reset mid-ACCESS -> no ack, all strobes high the next cycle, the held request is regranted from ch0 after reset release.
REQ-043 With GFX_ARB_UNDERRUN_EN and VGA_DEADLINE=4: a VGA request arriving one cycle into a write slot is served in time with no underrun; with RAM_WAIT=4, o_vga_underrun=1 and it stays set.
